hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline, replacing the purely combinational stall/forward unit. It keeps its own registered shadow pipeline of destination, write-enable, Tnew and forward-source information for the E, M and W stages, so only the D stage supplies decoded information each cycle. It adds multi-cycle multiply/divide (MDU) busy tracking and a saturating stall-cycle counter. It drives the PC/D-register enables, the E-register clear and every forwarding mux select.

---
 rtl/hazard_scoreboard_pkg.sv | 53 +++++
 rtl/hazard_scoreboard_if.sv | 40 ++++
 rtl/hazard_scoreboard_mdu_busy_ctr.sv | 33 +++
 rtl/hazard_scoreboard.sv | 133 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: forward encodings, MDU op classes and shadow-stage records.
// Shadow fields are sized for the widest supported REG_AW/TNEW_W; narrower values are zero-extended.
package hazard_scoreboard_pkg;

    localparam int SHD_AW = 8;
    localparam int SHD_TW = 4;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_t;

    localparam logic [SHD_TW-1:0] TUSE_NONE = '1;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_t;

    typedef struct packed {
        logic [SHD_AW-1:0] a3;
        logic              we;
        logic [SHD_TW-1:0] tnew;
    } producer_t;

    typedef struct packed {
        logic [SHD_AW-1:0] rs;
        logic [SHD_AW-1:0] rt;
        md_t               md_start;
        producer_t         dst;
    } shadow_t;

    // Past E only the store-data source and the destination record are still consulted.
    typedef struct packed {
        logic [SHD_AW-1:0] rt;
        producer_t         dst;
    } mem_shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '0;

    function automatic producer_t age_dst(input producer_t p);
        producer_t q;
        q = p;
        if (p.tnew != '0) begin
            q.tnew = p.tnew - 1'b1;
        end
        return q;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage decode inputs and hazard/forward control outputs of the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int TNEW_W = 2,
    parameter int PERF_W = 32
);
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [TNEW_W-1:0] d_tuse_rs;
    logic [TNEW_W-1:0] d_tuse_rt;
    logic [REG_AW-1:0] d_a3;
    logic              d_we;
    logic [TNEW_W-1:0] d_tnew;
    logic              d_md_use;
    logic [1:0]        d_md_start;

    logic              stall;
    logic              pc_en;
    logic              d_en;
    logic              e_clr;
    logic [1:0]        fwd_rs_d;
    logic [1:0]        fwd_rt_d;
    logic [1:0]        fwd_rs_e;
    logic [1:0]        fwd_rt_e;
    logic              fwd_rt_m;
    logic              mdu_busy;
    logic [PERF_W-1:0] stall_count;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_we, d_tnew, d_md_use, d_md_start,
        input  stall, pc_en, d_en, e_clr, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
               mdu_busy, stall_count
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_we, d_tnew, d_md_use, d_md_start,
        output stall, pc_en, d_en, e_clr, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
               mdu_busy, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard_mdu_busy_ctr.sv
// MDU busy tracker: loads the op latency while a mult/div sits in E, then counts down to idle.
module mdu_busy_ctr
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    input  md_t  i_md_start,
    output logic o_busy
);

    logic [CNT_W-1:0] r_count;
    logic             w_load;

    assign w_load = (i_md_start != MD_NONE);

    // A load always wins over the decrement.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= (i_md_start == MD_MULT) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_busy = w_load || (r_count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Registered hazard/forward controller: shadows E/M/W producer state, stalls D, selects forwarding
// sources and tracks MDU occupancy plus a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int TNEW_W   = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4,
    parameter int PERF_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);

    localparam logic [SHD_TW-1:0] TUSE_NONE_EXT = TUSE_NONE >> (SHD_TW - TNEW_W);

    shadow_t           r_e;
    mem_shadow_t       r_m;
    producer_t         r_w;
    logic [PERF_W-1:0] r_stall_count;

    shadow_t           w_d_shd;
    mem_shadow_t       w_m_next;
    producer_t         w_w_next;
    logic [SHD_AW-1:0] w_d_rs;
    logic [SHD_AW-1:0] w_d_rt;
    logic [SHD_TW-1:0] w_tuse_rs;
    logic [SHD_TW-1:0] w_tuse_rt;
    logic [2:0]        w_ready;
    logic [2:0]        w_match_rs_d;
    logic [2:0]        w_match_rt_d;
    logic [2:0]        w_match_rs_e;
    logic [2:0]        w_match_rt_e;
    logic              w_stall_rs;
    logic              w_stall_rt;
    logic              w_stall_md;
    logic              w_stall;
    logic              w_mdu_busy;

    function automatic logic is_prod(input producer_t p, input logic [SHD_AW-1:0] r);
        return p.we && (p.a3 == r) && (r != '0);
    endfunction

    function automatic logic too_late(input producer_t p, input logic [SHD_AW-1:0] r,
                                      input logic [SHD_TW-1:0] tuse);
        return is_prod(p, r) && (p.tnew > tuse);
    endfunction

    // Bit 0 = E, 1 = M, 2 = W; the nearest match decides, and an unready one selects the GRF.
    function automatic fwd_sel_t pick(input logic [2:0] match, input logic [2:0] ready);
        if (match[0]) return ready[0] ? FWD_E : FWD_RF;
        if (match[1]) return ready[1] ? FWD_M : FWD_RF;
        if (match[2]) return ready[2] ? FWD_W : FWD_RF;
        return FWD_RF;
    endfunction

    always_comb begin
        w_d_rs    = SHD_AW'(hz.d_rs);
        w_d_rt    = SHD_AW'(hz.d_rt);
        w_tuse_rs = SHD_TW'(hz.d_tuse_rs);
        w_tuse_rt = SHD_TW'(hz.d_tuse_rt);

        w_d_shd              = SHADOW_BUBBLE;
        w_d_shd.rs           = w_d_rs;
        w_d_shd.rt           = w_d_rt;
        w_d_shd.md_start     = md_t'(hz.d_md_start);
        w_d_shd.dst.a3       = SHD_AW'(hz.d_a3);
        w_d_shd.dst.we       = hz.d_we;
        w_d_shd.dst.tnew     = SHD_TW'(hz.d_tnew);

        w_m_next.rt  = r_e.rt;
        w_m_next.dst = age_dst(r_e.dst);
        w_w_next     = age_dst(r_m.dst);

        w_ready = {r_w.tnew == '0, r_m.dst.tnew == '0, r_e.dst.tnew == '0};

        w_match_rs_d = {is_prod(r_w, w_d_rs), is_prod(r_m.dst, w_d_rs), is_prod(r_e.dst, w_d_rs)};
        w_match_rt_d = {is_prod(r_w, w_d_rt), is_prod(r_m.dst, w_d_rt), is_prod(r_e.dst, w_d_rt)};
        w_match_rs_e = {is_prod(r_w, r_e.rs), is_prod(r_m.dst, r_e.rs), 1'b0};
        w_match_rt_e = {is_prod(r_w, r_e.rt), is_prod(r_m.dst, r_e.rt), 1'b0};

        w_stall_rs = (w_tuse_rs != TUSE_NONE_EXT) &&
                     (too_late(r_e.dst, w_d_rs, w_tuse_rs) || too_late(r_m.dst, w_d_rs, w_tuse_rs));
        w_stall_rt = (w_tuse_rt != TUSE_NONE_EXT) &&
                     (too_late(r_e.dst, w_d_rt, w_tuse_rt) || too_late(r_m.dst, w_d_rt, w_tuse_rt));
        w_stall_md = hz.d_md_use && w_mdu_busy;
        w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
    end

    // A stalled D instruction leaves a bubble in E while M and W keep draining.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e           <= SHADOW_BUBBLE;
            r_m           <= '0;
            r_w           <= '0;
            r_stall_count <= '0;
        end else begin
            r_e <= w_stall ? SHADOW_BUBBLE : w_d_shd;
            r_m <= w_m_next;
            r_w <= w_w_next;
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    mdu_busy_ctr #(
        .CNT_W    (CNT_W),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_mdu_busy_ctr (
        .clk        (clk),
        .reset      (reset),
        .i_md_start (r_e.md_start),
        .o_busy     (w_mdu_busy)
    );

    assign hz.stall       = w_stall;
    assign hz.pc_en       = !w_stall;
    assign hz.d_en        = !w_stall;
    assign hz.e_clr       = w_stall;
    assign hz.fwd_rs_d    = pick(w_match_rs_d, w_ready);
    assign hz.fwd_rt_d    = pick(w_match_rt_d, w_ready);
    assign hz.fwd_rs_e    = pick(w_match_rs_e, w_ready);
    assign hz.fwd_rt_e    = pick(w_match_rt_e, w_ready);
    assign hz.fwd_rt_m    = is_prod(r_w, r_m.rt) && w_ready[2];
    assign hz.mdu_busy    = w_mdu_busy;
    assign hz.stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios followed by random decode streams,
// every cycle compared against an instruction-age model of the pipeline.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int REG_AW   = 5;
    localparam int TNEW_W   = 2;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;
    localparam int PERF_W   = 32;
    localparam int TNONE    = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(REG_AW), .TNEW_W(TNEW_W), .PERF_W(PERF_W)) hz ();

    hazard_scoreboard #(
        .REG_AW(REG_AW), .TNEW_W(TNEW_W), .MULT_LAT(MULT_LAT),
        .DIV_LAT(DIV_LAT), .CNT_W(CNT_W), .PERF_W(PERF_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        int rs;
        int rt;
        int a3;
        int tnew;
        int md;
        bit we;
    } ins_t;

    // Instructions in flight, newest first: [0] in E, [1] in M, [2] in W.
    ins_t   pipe[$];
    longint cyc;
    longint busy_until;
    longint sc;
    bit     model_ok;
    int     n_vec;
    int     n_err;

    function automatic ins_t bubble();
        ins_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic int eff_tnew(int i);
        int t;
        t = pipe[i].tnew - i;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic bit prod(int i, int r);
        return pipe[i].we && (pipe[i].a3 == r) && (r != 0);
    endfunction

    function automatic bit data_stall(int r, int tuse);
        if (tuse == TNONE) return 1'b0;
        return (prod(0, r) && eff_tnew(0) > tuse) || (prod(1, r) && eff_tnew(1) > tuse);
    endfunction

    function automatic int fwd(int r, int first);
        for (int i = first; i < 3; i++) begin
            if (prod(i, r)) return (eff_tnew(i) == 0) ? i + 1 : 0;
        end
        return 0;
    endfunction

    function automatic bit busy_m();
        return (pipe[0].md != 0) || (cyc <= busy_until);
    endfunction

    function automatic void model_reset();
        pipe       = '{bubble(), bubble(), bubble()};
        busy_until = -1;
        sc         = 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst_n, input int rs, input int rt, input int tuse_rs,
                        input int tuse_rt, input int a3, input bit we, input int tnew,
                        input bit md_use, input int md);
        bit   ms;
        ins_t n;
        @(negedge clk);
        reset         = rst_n;
        hz.d_rs       = REG_AW'(rs);
        hz.d_rt       = REG_AW'(rt);
        hz.d_tuse_rs  = TNEW_W'(tuse_rs);
        hz.d_tuse_rt  = TNEW_W'(tuse_rt);
        hz.d_a3       = REG_AW'(a3);
        hz.d_we       = we;
        hz.d_tnew     = TNEW_W'(tnew);
        hz.d_md_use   = md_use;
        hz.d_md_start = 2'(md);
        #1;
        ms = data_stall(rs, tuse_rs) || data_stall(rt, tuse_rt) || (md_use && busy_m());
        if (model_ok) begin
            chk("stall",       hz.stall, ms);
            chk("pc_en",       hz.pc_en, !ms);
            chk("d_en",        hz.d_en, !ms);
            chk("e_clr",       hz.e_clr, ms);
            chk("fwd_rs_d",    hz.fwd_rs_d, fwd(rs, 0));
            chk("fwd_rt_d",    hz.fwd_rt_d, fwd(rt, 0));
            chk("fwd_rs_e",    hz.fwd_rs_e, fwd(pipe[0].rs, 1));
            chk("fwd_rt_e",    hz.fwd_rt_e, fwd(pipe[0].rt, 1));
            chk("fwd_rt_m",    hz.fwd_rt_m, fwd(pipe[1].rt, 2) == 3);
            chk("mdu_busy",    hz.mdu_busy, busy_m());
            chk("stall_count", hz.stall_count, sc);
        end
        if (!rst_n) begin
            model_reset();
            model_ok = 1'b1;
        end else begin
            if (pipe[0].md != 0) busy_until = cyc + ((pipe[0].md == 1) ? MULT_LAT : DIV_LAT);
            if (ms && sc != 64'hFFFF_FFFF) sc++;
            n    = '{rs: rs, rt: rt, a3: a3, tnew: tnew, md: md, we: we};
            pipe.push_front(ms ? bubble() : n);
            void'(pipe.pop_back());
        end
        cyc++;
    endtask

    task automatic nop(input bit rst_n);
        step(rst_n, 0, 0, TNONE, TNONE, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic mflo(input bit rst_n);
        step(rst_n, 0, 0, TNONE, TNONE, 12, 1'b1, 1, 1'b1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  stalls;
        bit  issued;
        int  rs, rt, tr, tt, a3, tn, md, pk;
        bit  we, mu, rn;

        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        model_ok = 1'b0;
        model_reset();
        hz.d_rs = '0; hz.d_rt = '0; hz.d_tuse_rs = '1; hz.d_tuse_rt = '1;
        hz.d_a3 = '0; hz.d_we = 1'b0; hz.d_tnew = '0; hz.d_md_use = 1'b0; hz.d_md_start = '0;

        nop(1'b0);
        nop(1'b0);
        nop(1'b1);
        chk("rst_stall", hz.stall, 0);
        chk("rst_pc_en", hz.pc_en, 1);
        chk("rst_e_clr", hz.e_clr, 0);
        chk("rst_busy",  hz.mdu_busy, 0);
        chk("rst_count", hz.stall_count, 0);

        // lw $8 then addu using $8
        step(1'b1, 29, 0, 1, TNONE, 8, 1'b1, 2, 1'b0, 0);
        step(1'b1, 8, 9, 1, 1, 10, 1'b1, 1, 1'b0, 0);
        chk("lu_stall", hz.stall, 1);
        step(1'b1, 8, 9, 1, 1, 10, 1'b1, 1, 1'b0, 0);
        chk("lu_release", hz.stall, 0);
        chk("lu_fwd_d", hz.fwd_rs_d, 0);
        nop(1'b1);
        chk("lu_fwd_e", hz.fwd_rs_e, 3);
        chk("lu_count", hz.stall_count, 1);
        repeat (3) nop(1'b1);

        // addu $9 then beq on $9
        step(1'b1, 0, 0, TNONE, TNONE, 9, 1'b1, 1, 1'b0, 0);
        step(1'b1, 9, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0);
        chk("br_stall", hz.stall, 1);
        step(1'b1, 9, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0);
        chk("br_release", hz.stall, 0);
        chk("br_fwd_d", hz.fwd_rs_d, 2);
        repeat (3) nop(1'b1);

        // jal then jr $31
        step(1'b1, 0, 0, TNONE, TNONE, 31, 1'b1, 0, 1'b0, 0);
        step(1'b1, 31, 0, 0, TNONE, 0, 1'b0, 0, 1'b0, 0);
        chk("jr_stall", hz.stall, 0);
        chk("jr_fwd_d", hz.fwd_rs_d, 1);
        repeat (3) nop(1'b1);

        // writes to $0 never hazard
        step(1'b1, 0, 0, TNONE, TNONE, 0, 1'b1, 2, 1'b0, 0);
        step(1'b1, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0);
        chk("r0_stall", hz.stall, 0);
        chk("r0_fwd_rs", hz.fwd_rs_d, 0);
        chk("r0_fwd_rt", hz.fwd_rt_d, 0);

        // mult then mflo
        nop(1'b0);
        nop(1'b1);
        step(1'b1, 4, 5, 1, 1, 0, 1'b0, 0, 1'b1, 1);
        chk("mul_issue", hz.stall, 0);
        stalls = 0;
        issued = 1'b0;
        for (int k = 0; k < 20 && !issued; k++) begin
            mflo(1'b1);
            if (hz.stall) begin
                stalls++;
            end else begin
                issued = 1'b1;
                chk("mul_busy_at_issue", hz.mdu_busy, 0);
            end
        end
        chk("mul_issued", issued, 1);
        chk("mul_stalls", stalls, 6);
        chk("mul_count", hz.stall_count, 6);

        // div, reset at countdown 7
        nop(1'b1);
        nop(1'b1);
        step(1'b1, 4, 5, 1, 1, 0, 1'b0, 0, 1'b1, 2);
        repeat (4) mflo(1'b1);
        mflo(1'b0);
        chk("div_busy_pre", hz.mdu_busy, 1);
        mflo(1'b1);
        chk("div_busy_post", hz.mdu_busy, 0);
        chk("div_stall_post", hz.stall, 0);
        chk("div_count_post", hz.stall_count, 0);

        for (int k = 0; k < 700; k++) begin
            rs = $urandom_range(0, 3);
            rt = $urandom_range(0, 3);
            tr = $urandom_range(0, 3);
            tt = $urandom_range(0, 3);
            a3 = $urandom_range(0, 3);
            we = ($urandom_range(0, 3) != 0);
            tn = $urandom_range(0, 3);
            pk = $urandom_range(0, 15);
            md = (pk == 0) ? 1 : ((pk == 1) ? 2 : 0);
            mu = (md != 0) || ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 63) != 0);
            step(rn, rs, rt, tr, tt, a3, we, tn, mu, md);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
